// File: rtl/ext_mem_sample_scheduler_if.sv
// ---------------------------------------------------------------------------
// ext_mem_sample_scheduler_if
// Avalon-MM-like command/response bundle between the sample scheduler and
// one external memory port (e.g. an SDRAM controller).
//   mem_address_o        {client index, client address}
//   mem_write_o          write strobe, held while mem_waitrequest_i is high
//   mem_writedata_o      write data
//   mem_read_o           read strobe, held while mem_waitrequest_i is high
//   mem_waitrequest_i    command stall from the memory
//   mem_readdatavalid_i  read data return qualifier
//   mem_readdata_i       read data
// The _o/_i suffixes are relative to the scheduler (master modport).
// ---------------------------------------------------------------------------
interface ext_mem_sample_scheduler_if #(
  parameter int AWIDTH = 18,
  parameter int DWIDTH = 16
) ();
  logic [AWIDTH-1:0] mem_address_o;
  logic              mem_write_o;
  logic [DWIDTH-1:0] mem_writedata_o;
  logic              mem_read_o;
  logic              mem_waitrequest_i;
  logic              mem_readdatavalid_i;
  logic [DWIDTH-1:0] mem_readdata_i;

  modport master (
    output mem_address_o, mem_write_o, mem_writedata_o, mem_read_o,
    input  mem_waitrequest_i, mem_readdatavalid_i, mem_readdata_i
  );

  modport slave (
    input  mem_address_o, mem_write_o, mem_writedata_o, mem_read_o,
    output mem_waitrequest_i, mem_readdatavalid_i, mem_readdata_i
  );
endinterface

// File: rtl/ext_mem_sample_scheduler.sv
// ---------------------------------------------------------------------------
// ext_mem_sample_scheduler
// Shares one external memory port between N_CLIENTS sample-rate delay lines.
// On each sample tick every client may post one write and one read; the
// round is then serialised in fixed client order (write before read of the
// same client). Read results are published to the clients at the next tick.
// Ports:
//   clk_i, srst_i            clock, synchronous active-high reset
//   sample_tick_i            one-cycle pulse per audio sample
//   cl_write_enable_i/_address_i, cl_writedata_i   per-client write request
//   cl_read_enable_i/_address_i                    per-client read request
//   cl_readdata_o, cl_readdata_valid_o             published read results
//   mem_if                   memory master port (see the interface file)
//   busy_o                   a round is in progress
//   overrun_o                one-cycle pulse: tick arrived while busy
// ---------------------------------------------------------------------------
module ext_mem_sample_scheduler #(
  parameter int N_CLIENTS = 4,
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 16
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic                        sample_tick_i,
  input  logic [N_CLIENTS-1:0]        cl_write_enable_i,
  input  logic [N_CLIENTS*AWIDTH-1:0] cl_write_address_i,
  input  logic [N_CLIENTS*DWIDTH-1:0] cl_writedata_i,
  input  logic [N_CLIENTS-1:0]        cl_read_enable_i,
  input  logic [N_CLIENTS*AWIDTH-1:0] cl_read_address_i,
  output logic [N_CLIENTS*DWIDTH-1:0] cl_readdata_o,
  output logic [N_CLIENTS-1:0]        cl_readdata_valid_o,
  ext_mem_sample_scheduler_if.master  mem_if,
  output logic                        busy_o,
  output logic                        overrun_o
);
  localparam int CWIDTH = $clog2(N_CLIENTS);
  // idx has to be able to reach N_CLIENTS to signal the end of a round
  localparam int IWIDTH = CWIDTH + 1;

  typedef enum logic [2:0] {IDLE_S, SEL_S, WRITE_S, READ_S, WAIT_S} state_t;

  state_t                     state_reg;
  logic [IWIDTH-1:0]          idx_reg;
  logic [CWIDTH-1:0]          slot;
  logic                       idx_done;

  // Request shadows, captured on the tick that starts a round
  logic [N_CLIENTS-1:0]       wr_en_reg;
  logic [N_CLIENTS-1:0]       rd_en_reg;
  logic [AWIDTH-1:0]          wr_addr_reg [N_CLIENTS];
  logic [DWIDTH-1:0]          wr_data_reg [N_CLIENTS];
  logic [AWIDTH-1:0]          rd_addr_reg [N_CLIENTS];

  // Results of the round in flight, and of the last finished round
  logic [DWIDTH-1:0]          hold_reg [N_CLIENTS];
  logic [N_CLIENTS-1:0]       round_valid_reg;
  logic [N_CLIENTS*DWIDTH-1:0] done_data_reg;
  logic [N_CLIENTS-1:0]       done_valid_reg;
  logic                       done_pend_reg;
  logic                       overrun_reg;

  logic [AWIDTH-1:0]          wr_addr_in [N_CLIENTS];
  logic [DWIDTH-1:0]          wr_data_in [N_CLIENTS];
  logic [AWIDTH-1:0]          rd_addr_in [N_CLIENTS];

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_unpack
    assign wr_addr_in[gi] = cl_write_address_i[gi*AWIDTH +: AWIDTH];
    assign wr_data_in[gi] = cl_writedata_i[gi*DWIDTH +: DWIDTH];
    assign rd_addr_in[gi] = cl_read_address_i[gi*AWIDTH +: AWIDTH];
  end

  assign slot      = idx_reg[CWIDTH-1:0];
  assign idx_done  = (idx_reg == IWIDTH'(N_CLIENTS));
  assign busy_o    = (state_reg != IDLE_S);
  assign overrun_o = overrun_reg;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg              <= IDLE_S;
      idx_reg                <= '0;
      wr_en_reg              <= '0;
      rd_en_reg              <= '0;
      for (int k = 0; k < N_CLIENTS; k++) begin
        wr_addr_reg[k] <= '0;
        wr_data_reg[k] <= '0;
        rd_addr_reg[k] <= '0;
        hold_reg[k]    <= '0;
      end
      round_valid_reg        <= '0;
      done_data_reg          <= '0;
      done_valid_reg         <= '0;
      done_pend_reg          <= 1'b0;
      overrun_reg            <= 1'b0;
      cl_readdata_o          <= '0;
      cl_readdata_valid_o    <= '0;
      mem_if.mem_address_o   <= '0;
      mem_if.mem_write_o     <= 1'b0;
      mem_if.mem_writedata_o <= '0;
      mem_if.mem_read_o      <= 1'b0;
    end else begin
      overrun_reg <= sample_tick_i && (state_reg != IDLE_S);

      // Publication happens on every tick; a tick that finds no finished
      // round since the previous publication publishes an empty result.
      if (sample_tick_i) begin
        done_pend_reg <= 1'b0;
        if (done_pend_reg) begin
          cl_readdata_o       <= done_data_reg;
          cl_readdata_valid_o <= done_valid_reg;
        end else begin
          cl_readdata_o       <= '0;
          cl_readdata_valid_o <= '0;
        end
      end

      case (state_reg)
        IDLE_S: begin
          if (sample_tick_i) begin
            wr_en_reg       <= cl_write_enable_i;
            rd_en_reg       <= cl_read_enable_i;
            wr_addr_reg     <= wr_addr_in;
            wr_data_reg     <= wr_data_in;
            rd_addr_reg     <= rd_addr_in;
            idx_reg         <= '0;
            round_valid_reg <= '0;
            state_reg       <= SEL_S;
          end
        end

        SEL_S: begin
          if (idx_done) begin
            // Placed after the publication block so a same-cycle tick
            // cannot clear the pending flag of the round finishing now.
            for (int k = 0; k < N_CLIENTS; k++) begin
              done_data_reg[k*DWIDTH +: DWIDTH] <= round_valid_reg[k] ? hold_reg[k] : '0;
            end
            done_valid_reg <= round_valid_reg;
            done_pend_reg  <= 1'b1;
            state_reg      <= IDLE_S;
          end else if (wr_en_reg[slot]) begin
            mem_if.mem_write_o     <= 1'b1;
            mem_if.mem_address_o   <= {slot, wr_addr_reg[slot]};
            mem_if.mem_writedata_o <= wr_data_reg[slot];
            state_reg              <= WRITE_S;
          end else if (rd_en_reg[slot]) begin
            mem_if.mem_read_o    <= 1'b1;
            mem_if.mem_address_o <= {slot, rd_addr_reg[slot]};
            state_reg            <= READ_S;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end

        WRITE_S: begin
          if (!mem_if.mem_waitrequest_i) begin
            mem_if.mem_write_o <= 1'b0;
            if (rd_en_reg[slot]) begin
              // Go straight to the read of the same client
              mem_if.mem_read_o    <= 1'b1;
              mem_if.mem_address_o <= {slot, rd_addr_reg[slot]};
              state_reg            <= READ_S;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= SEL_S;
            end
          end
        end

        READ_S: begin
          if (!mem_if.mem_waitrequest_i) begin
            mem_if.mem_read_o <= 1'b0;
            state_reg         <= WAIT_S;
          end
        end

        WAIT_S: begin
          // readdatavalid is only honoured here, so returns left over from
          // an abandoned round are dropped.
          if (mem_if.mem_readdatavalid_i) begin
            hold_reg[slot]        <= mem_if.mem_readdata_i;
            round_valid_reg[slot] <= 1'b1;
            idx_reg               <= idx_reg + 1'b1;
            state_reg             <= SEL_S;
          end
        end

        default: state_reg <= IDLE_S;
      endcase
    end
  end
endmodule

// File: tb/tb_ext_mem_sample_scheduler.sv
module tb_ext_mem_sample_scheduler;
  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int CW  = 1;
  localparam int MAW = AW + CW;

  typedef struct packed {
    logic [N-1:0]    we;
    logic [N*AW-1:0] wa;
    logic [N*DW-1:0] wd;
    logic [N-1:0]    re;
    logic [N*AW-1:0] ra;
  } req_t;

  logic            clk;
  logic            srst;
  logic            tick;
  logic [N-1:0]    wr_en;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    rd_en;
  logic [N*AW-1:0] rd_addr;
  logic [N*DW-1:0] readdata;
  logic [N-1:0]    readdata_valid;
  logic            busy;
  logic            overrun;

  ext_mem_sample_scheduler_if #(.AWIDTH(MAW), .DWIDTH(DW)) mem_if ();

  ext_mem_sample_scheduler #(.N_CLIENTS(N), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i              (clk),
    .srst_i             (srst),
    .sample_tick_i      (tick),
    .cl_write_enable_i  (wr_en),
    .cl_write_address_i (wr_addr),
    .cl_writedata_i     (wr_data),
    .cl_read_enable_i   (rd_en),
    .cl_read_address_i  (rd_addr),
    .cl_readdata_o      (readdata),
    .cl_readdata_valid_o(readdata_valid),
    .mem_if             (mem_if.master),
    .busy_o             (busy),
    .overrun_o          (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Contents of never-written memory locations
  function automatic logic [DW-1:0] init_val(input logic [MAW-1:0] a);
    return a[DW-1:0] ^ 16'hC3A5 ^ {a[MAW-1], 15'h0};
  endfunction

  // ---------------- memory slave (environment) ----------------
  logic [DW-1:0] slave_mem [logic [MAW-1:0]];
  logic [63:0]   log_q [$];
  int            dur_q [$];
  int            stall_max = 0;
  int            stall_next = -1;
  int            rd_extra = 0;

  initial begin
    int            stall_left;
    int            cmd_dur;
    int            rd_cnt;
    bit            in_cmd;
    logic [MAW-1:0] cmd_addr;
    logic [DW-1:0]  cmd_data;
    logic [DW-1:0]  rd_pend;
    stall_left = 0; cmd_dur = 0; rd_cnt = 0; in_cmd = 0;
    cmd_addr = '0; cmd_data = '0; rd_pend = '0;
    mem_if.mem_waitrequest_i   = 1'b0;
    mem_if.mem_readdatavalid_i = 1'b0;
    mem_if.mem_readdata_i      = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_readdatavalid_i = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_if.mem_readdatavalid_i = 1'b1;
          mem_if.mem_readdata_i      = rd_pend;
        end
      end
      if (mem_if.mem_write_o || mem_if.mem_read_o) begin
        check("one_strobe", 64'(mem_if.mem_write_o && mem_if.mem_read_o), 64'd0);
        if (!in_cmd) begin
          in_cmd   = 1;
          cmd_dur  = 0;
          cmd_addr = mem_if.mem_address_o;
          cmd_data = mem_if.mem_writedata_o;
          stall_left = (stall_next >= 0) ? stall_next : int'($urandom_range(0, stall_max));
          stall_next = -1;
        end else begin
          check("addr_stable", 64'(mem_if.mem_address_o), 64'(cmd_addr));
          if (mem_if.mem_write_o)
            check("data_stable", 64'(mem_if.mem_writedata_o), 64'(cmd_data));
        end
        cmd_dur++;
        if (stall_left > 0) begin
          mem_if.mem_waitrequest_i = 1'b1;
          stall_left--;
        end else begin
          mem_if.mem_waitrequest_i = 1'b0;
          in_cmd = 0;
          log_q.push_back(64'({mem_if.mem_write_o, mem_if.mem_address_o,
                               mem_if.mem_write_o ? mem_if.mem_writedata_o : 16'h0}));
          dur_q.push_back(cmd_dur);
          if (mem_if.mem_write_o) begin
            slave_mem[mem_if.mem_address_o] = mem_if.mem_writedata_o;
          end else begin
            rd_pend = slave_mem.exists(mem_if.mem_address_o) ?
                      slave_mem[mem_if.mem_address_o] : init_val(mem_if.mem_address_o);
            rd_cnt  = 1 + rd_extra;
          end
        end
      end else begin
        in_cmd = 0;
        mem_if.mem_waitrequest_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0]   model_mem [logic [MAW-1:0]];
  logic [63:0]     exp_q [$];
  int              exp_busy;
  logic [N-1:0]    nxt_valid;
  logic [N*DW-1:0] nxt_data;
  logic [N-1:0]    pub_valid = '0;
  logic [N*DW-1:0] pub_data = '0;
  bit              exp_pend = 0;
  int              round_no = 0;

  // Fixed client order; a client's write goes before its read; a round
  // spends one select cycle per client, one per write, two per read, and a
  // final select.
  task automatic model_round(input req_t r);
    logic [MAW-1:0] fa;
    exp_q.delete();
    nxt_valid = r.re;
    nxt_data  = '0;
    exp_busy  = 1;
    for (int k = 0; k < N; k++) begin
      exp_busy += 1;
      if (r.we[k]) begin
        fa = {CW'(k), r.wa[k*AW +: AW]};
        exp_q.push_back(64'({1'b1, fa, r.wd[k*DW +: DW]}));
        model_mem[fa] = r.wd[k*DW +: DW];
        exp_busy += 1;
      end
      if (r.re[k]) begin
        fa = {CW'(k), r.ra[k*AW +: AW]};
        exp_q.push_back(64'({1'b0, fa, 16'h0}));
        nxt_data[k*DW +: DW] = model_mem.exists(fa) ? model_mem[fa] : init_val(fa);
        exp_busy += 2;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic req_t rand_req();
    req_t r;
    r.we = N'($urandom); r.re = N'($urandom);
    for (int k = 0; k < N; k++) begin
      r.wa[k*AW +: AW] = AW'($urandom_range(0, 7));
      r.ra[k*AW +: AW] = AW'($urandom_range(0, 7));
      r.wd[k*DW +: DW] = DW'($urandom);
    end
    return r;
  endfunction

  task automatic apply(input req_t r);
    wr_en = r.we; wr_addr = r.wa; wr_data = r.wd; rd_en = r.re; rd_addr = r.ra;
  endtask

  task automatic do_tick(input req_t r, input logic exp_ovr);
    @(negedge clk);
    apply(r);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    apply(rand_req());  // must be ignored off-tick
    check("pub_valid", 64'(readdata_valid), exp_pend ? 64'(pub_valid) : 64'd0);
    check("pub_data", 64'(readdata), exp_pend ? 64'(pub_data) : 64'd0);
    check("overrun", 64'(overrun), 64'(exp_ovr));
    exp_pend = 0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    check("round_end", 64'(busy), 64'd0);
  endtask

  task automatic compare_log();
    int n;
    check("cmd_count", 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("cmd", log_q[i], exp_q[i]);
  endtask

  task automatic normal_round(input req_t r, input bit chk_busy, input int extra);
    int cyc;
    log_q.delete(); dur_q.delete();
    do_tick(r, 1'b0);
    model_round(r);
    wait_idle(cyc);
    if (chk_busy) check("busy_cycles", 64'(cyc), 64'(exp_busy + extra));
    compare_log();
    pub_valid = nxt_valid; pub_data = nxt_data; exp_pend = 1;
    $display("round %0d: we=%b re=%b cmds=%0d busy=%0d", round_no, r.we, r.re, log_q.size(), cyc);
    round_no++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    req_t empty;
    int   cyc;
    int   w;
    empty = '0;
    srst = 1'b1; tick = 1'b0; apply(empty);
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    check("rst_readdata", 64'(readdata), 64'd0);
    check("rst_valid", 64'(readdata_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_strobes", 64'({mem_if.mem_write_o, mem_if.mem_read_o}), 64'd0);
    check("rst_addr", 64'(mem_if.mem_address_o), 64'd0);

    // 1: write+read client 0, read client 1, zero-wait memory
    r = empty;
    r.we = 2'b01; r.wa = {16'h0000, 16'h0010}; r.wd = {16'h0000, 16'h1234};
    r.re = 2'b11; r.ra = {16'h0005, 16'h0010};
    normal_round(r, 1, 0);
    check("t1_cmd0", log_q[0], 64'({1'b1, 17'h00010, 16'h1234}));
    check("t1_busy_total", 64'(exp_busy), 64'd8);
    // 2: three waitrequest cycles on the first write; next tick publishes test 1
    r = empty;
    r.we = 2'b11; r.wa = {16'h0002, 16'h0011}; r.wd = {16'h5555, 16'hABCD};
    r.re = 2'b01; r.ra = {16'h0000, 16'h0011};
    stall_next = 3;
    normal_round(r, 1, 3);
    check("t2_write_hold", 64'(dur_q.size() > 0 ? dur_q[0] : 0), 64'd4);
    // 3: no requests
    normal_round(empty, 1, 0);
    check("t3_busy", 64'(exp_busy), 64'd3);
    normal_round(empty, 1, 0);  // publishes the empty round: valid=0
    // 6: client 0 write only, client 1 read only
    r = empty;
    r.we = 2'b01; r.wa = {16'h0000, 16'h0003}; r.wd = {16'h0000, 16'h0F0F};
    r.re = 2'b10; r.ra = {16'h0003, 16'h0000};
    normal_round(r, 1, 0);
    normal_round(empty, 1, 0);
    check("t6_valid_const", 64'(readdata_valid), 64'b10);

    // 4: slow read return, tick every 40 cycles -> overrun
    rd_extra = 50;
    r = empty;
    r.we = 2'b01; r.wa = {16'h0000, 16'h0020}; r.wd = {16'h0000, 16'h1111};
    r.re = 2'b11; r.ra = {16'h0031, 16'h0020};
    log_q.delete();
    do_tick(r, 1'b0);
    model_round(r);
    repeat (38) @(negedge clk);
    r = empty;
    r.we = 2'b01; r.wa = {16'h0000, 16'h0BAD}; r.wd = {16'h0000, 16'hDEAD};
    r.re = 2'b10; r.ra = {16'h0BAD, 16'h0000};
    do_tick(r, 1'b1);
    @(negedge clk);
    check("t4_overrun_pulse", 64'(overrun), 64'd0);
    wait_idle(cyc);
    compare_log();
    pub_valid = nxt_valid; pub_data = nxt_data; exp_pend = 1;
    $display("round %0d: overrun round cmds=%0d", round_no, log_q.size());
    round_no++;
    rd_extra = 0;
    normal_round(empty, 1, 0);

    // 5: reset while waiting for read data
    rd_extra = 30;
    r = empty;
    r.re = 2'b11; r.ra = {16'h0041, 16'h0040};
    log_q.delete();
    do_tick(r, 1'b0);
    w = 0;
    while (log_q.size() == 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("t5_read_issued", 64'(log_q.size()), 64'd1);
    repeat (3) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("t5_strobes", 64'({mem_if.mem_write_o, mem_if.mem_read_o}), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_valid", 64'(readdata_valid), 64'd0);
    check("t5_data", 64'(readdata), 64'd0);
    exp_pend = 0;
    rd_extra = 0;
    repeat (40) @(negedge clk);  // stale readdatavalid arrives while idle
    r = empty;
    r.we = 2'b10; r.wa = {16'h0041, 16'h0000}; r.wd = {16'h7777, 16'h0000};
    r.re = 2'b01; r.ra = {16'h0000, 16'h0040};
    normal_round(r, 1, 0);
    normal_round(empty, 1, 0);

    // Randomised rounds
    for (int n = 0; n < 40; n++) begin
      stall_max = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 3));
      rd_extra  = $urandom_range(0, 4);
      r = rand_req();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      normal_round(r, stall_max == 0, $countones(r.re) * rd_extra);
    end
    stall_max = 0; rd_extra = 0;
    normal_round(empty, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
